// File: rtl/neuron_accum_writer.sv
// neuron_accum_writer
//   Output stage of the conv engine. Accumulates TERMS signed partial products
//   per output neuron, adds the channel bias, saturates to DATA_W and writes the
//   result to the output feature-map memory. Address and lane are generated
//   internally: addr = (ch/LANES)*PLANE_SIZE + pix, lane = ch%LANES.
//
//   Build option: define RELU_EN to clamp negative saturated results to zero.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse, begins a layer when idle
//   in_valid/in_data    signed partial product stream, in_ready = accept
//   bias                signed bias of channel ch_idx, sampled in WRITE
//   ch_idx              current output channel (bias lookup)
//   wr_en/wr_addr/wr_lane/wr_data   output memory write port
//   neuron_done         pulse with every write
//   plane_done          pulse with the write of the last pixel of a plane
//   layer_done          pulse one cycle after the final write of the layer
//   busy                high whenever not idle
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start, no input accepted
// S_ACCUM | accepting partial products into the accumulator
// S_WRITE | one cycle: bias add, saturate, register the write, step pix/ch
// S_DONE  | layer finished, layer_done follows next cycle

module neuron_accum_writer #(
   parameter int DATA_W     = 16,
   parameter int ACC_W      = 32,
   parameter int TERMS      = 25,
   parameter int PLANE_SIZE = 784,
   parameter int OUT_CH     = 8,
   parameter int LANES      = 4,
   parameter int ADDR_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [DATA_W-1:0] bias,
   output logic [7:0]        ch_idx,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [1:0]        wr_lane,
   output logic [DATA_W-1:0] wr_data,
   output logic              neuron_done,
   output logic              plane_done,
   output logic              layer_done,
   output logic              busy
);

   localparam int TERM_W  = (TERMS > 1) ? $clog2(TERMS) : 1;
   localparam int PIX_W   = (PLANE_SIZE > 1) ? $clog2(PLANE_SIZE) : 1;
   localparam int LANE_SH = $clog2(LANES);

   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2**(DATA_W-1)) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - 1;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_WRITE, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [TERM_W-1:0]   term_q, term_d;
   logic [PIX_W-1:0]    pix_q, pix_d;
   logic [7:0]          ch_q, ch_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [1:0]          wr_lane_q, wr_lane_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                plane_done_q, plane_done_d;
   logic                layer_done_q, layer_done_d;

   logic signed [ACC_W:0]    sum;
   logic signed [DATA_W-1:0] sat_val;

   // bias add one bit wider than the accumulator so the sum itself cannot wrap
   always_comb begin
      sum = $signed({acc_q[ACC_W-1], acc_q})
          + $signed({{(ACC_W+1-DATA_W){bias[DATA_W-1]}}, bias});
      if (sum > SAT_MAX) begin
         sat_val = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (sum < SAT_MIN) begin
         sat_val = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         sat_val = sum[DATA_W-1:0];
      end
   end

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      term_d       = term_q;
      pix_d        = pix_q;
      ch_d         = ch_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_lane_d    = wr_lane_q;
      wr_data_d    = wr_data_q;
      plane_done_d = 1'b0;
      layer_done_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ACCUM;
               acc_d   = '0;
               term_d  = TERM_W'(TERMS - 1);
               pix_d   = '0;
               ch_d    = '0;
            end
         end
         S_ACCUM: begin
            if (in_valid) begin
               acc_d = acc_q + {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
               // term_q counts down the beats still owed; zero marks the last one
               if (term_q == '0) begin
                  state_d = S_WRITE;
               end else begin
                  term_d = term_q - 1'b1;
               end
            end
         end
         S_WRITE: begin
            wr_en_d   = 1'b1;
`ifdef RELU_EN
            wr_data_d = sat_val[DATA_W-1] ? '0 : sat_val;
`else
            wr_data_d = sat_val;
`endif
            wr_addr_d = ADDR_W'(32'(ch_q >> LANE_SH) * 32'(PLANE_SIZE) + 32'(pix_q));
            wr_lane_d = 2'(ch_q % 8'(LANES));
            acc_d     = '0;
            term_d    = TERM_W'(TERMS - 1);
            state_d   = S_ACCUM;
            if (pix_q == PIX_W'(PLANE_SIZE - 1)) begin
               pix_d        = '0;
               plane_done_d = 1'b1;
               ch_d         = ch_q + 8'd1;
               if (ch_q == 8'(OUT_CH - 1)) begin
                  state_d = S_DONE;
               end
            end else begin
               pix_d = pix_q + 1'b1;
            end
         end
         S_DONE: begin
            layer_done_d = 1'b1;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         acc_q        <= '0;
         term_q       <= '0;
         pix_q        <= '0;
         ch_q         <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_lane_q    <= '0;
         wr_data_q    <= '0;
         plane_done_q <= 1'b0;
         layer_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         term_q       <= term_d;
         pix_q        <= pix_d;
         ch_q         <= ch_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_lane_q    <= wr_lane_d;
         wr_data_q    <= wr_data_d;
         plane_done_q <= plane_done_d;
         layer_done_q <= layer_done_d;
      end
   end

   assign in_ready    = (state_q == S_ACCUM);
   assign busy        = (state_q != S_IDLE);
   assign ch_idx      = ch_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_lane     = wr_lane_q;
   assign wr_data     = wr_data_q;
   assign neuron_done = wr_en_q;
   assign plane_done  = plane_done_q;
   assign layer_done  = layer_done_q;

endmodule

// File: tb/tb_neuron_accum_writer.sv
module tb_neuron_accum_writer;

   localparam int TERMS = 3;
   localparam int PS    = 4;
   localparam int OC    = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready;
   logic [15:0] bias = '0;
   logic [7:0]  ch_idx;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [1:0]  wr_lane;
   logic [15:0] wr_data;
   logic        neuron_done, plane_done, layer_done, busy;

   neuron_accum_writer #(
      .DATA_W(16), .ACC_W(32), .TERMS(TERMS), .PLANE_SIZE(PS),
      .OUT_CH(OC), .LANES(4), .ADDR_W(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .bias(bias), .ch_idx(ch_idx),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane(wr_lane), .wr_data(wr_data),
      .neuron_done(neuron_done), .plane_done(plane_done),
      .layer_done(layer_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int     total = 0;
   int     bad   = 0;
   longint cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      longint      cyc;
      logic [15:0] data;
      logic [15:0] addr;
      logic [1:0]  lane;
      logic        plane;
   } exp_t;

   exp_t        exp_q[$];
   longint      exp_layer_cyc = -1;
   int          n = 0;
   int          wcount = 0;
   logic        prev_wr = 1'b0;
   logic [15:0] cap_data[64];
   logic [15:0] cap_addr[64];
   logic [1:0]  cap_lane[64];

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // saturate to 16-bit signed, optional relu
   function automatic logic [15:0] model_out(input longint s);
      longint r;
      r = s;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
`ifdef RELU_EN
      if (r < 0) r = 0;
`endif
      return 16'(r);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      chk("neuron_done", neuron_done, wr_en);
      chk("layer_done", layer_done, (cyc == exp_layer_cyc) ? 1 : 0);
      if (wr_en) begin
         chk("wr_back_to_back", prev_wr, 0);
         if (exp_q.size() == 0) begin
            chk("wr_unexpected", wr_en, 0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_cycle", cyc, e.cyc);
            chk("wr_data", wr_data, e.data);
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_lane", wr_lane, e.lane);
            chk("plane_done", plane_done, e.plane);
            if (wcount < 64) begin
               cap_data[wcount] = wr_data;
               cap_addr[wcount] = wr_addr;
               cap_lane[wcount] = wr_lane;
            end
            wcount++;
         end
      end else begin
         chk("plane_done_idle", plane_done, 0);
      end
      prev_wr = wr_en;
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         chk("wr_missing", cyc, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
   end

   task automatic do_start();
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_busy", busy, 1);
      n = 0;
   endtask

   // one neuron: three products, optional gaps, start pulse, in_valid held in WRITE
   task automatic drive_neuron(input int p0, input int p1, input int p2, input int b,
                               input bit gap, input bit hold, input bit spulse);
      int     p[3];
      int     pix, ch;
      longint s, k;
      exp_t   e;
      p[0] = p0; p[1] = p1; p[2] = p2;
      pix = n % PS;
      ch  = n / PS;
      bias = 16'(b);
      chk("ch_idx", ch_idx, ch);
      k = 0;
      for (int i = 0; i < 3; i++) begin
         if (gap && i > 0) begin
            in_valid = 1'b0;
            in_data  = 16'h1234;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = 16'(p[i]);
         chk("accum_in_ready", in_ready, 1);
         if (spulse && i == 1) start = 1'b1;
         if (i == 2) begin
            k = cyc;
            s = longint'(p0) + longint'(p1) + longint'(p2) + longint'(b);
            e.cyc   = k + 2;
            e.data  = model_out(s);
            e.addr  = 16'((ch / 4) * PS + pix);
            e.lane  = 2'(ch % 4);
            e.plane = (pix == PS - 1);
            exp_q.push_back(e);
            if (n == PS * OC - 1) exp_layer_cyc = k + 3;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("write_in_ready", in_ready, 0);
      chk("write_busy", busy, 1);
      if (hold) begin
         in_valid = 1'b1;
         in_data  = 16'd1000;
      end else begin
         in_valid = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ch_idx", ch_idx, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // full layer of 20 neurons, first four are the directed corner cases
      do_start();
      drive_neuron(1, 2, 3, 4, 0, 0, 0);
      drive_neuron(32767, 32767, 32767, 32767, 0, 0, 0);
      drive_neuron(-32768, -32768, -32768, 0, 0, 0, 0);
      drive_neuron(4, 5, 6, -20, 1, 0, 0);
      for (int i = 4; i < PS * OC; i++) begin
         drive_neuron(i * 100, -(i * 37), i + 7, (i / PS) * 3 - 5, 0, (i == 5), (i == 5));
      end
      @(posedge clk); #1;
      chk("layer_done_now", layer_done, 1);
      chk("busy_after_layer", busy, 0);
      repeat (2) @(posedge clk);
      #1;

      chk("t1_data", cap_data[0], 10);
      chk("t1_addr", cap_addr[0], 0);
      chk("t1_lane", cap_lane[0], 0);
      chk("t3_pos_sat", cap_data[1], 16'h7FFF);
`ifdef RELU_EN
      chk("t3_neg_sat", cap_data[2], 16'h0000);
      chk("t4_gapped", cap_data[3], 16'h0000);
`else
      chk("t3_neg_sat", cap_data[2], 16'h8000);
      chk("t4_gapped", cap_data[3], 16'hFFFB);
`endif
      for (int j = 0; j < 4; j++) begin
         chk("ch3_addr", cap_addr[12 + j], j);
         chk("ch3_lane", cap_lane[12 + j], 3);
         chk("ch4_addr", cap_addr[16 + j], 4 + j);
         chk("ch4_lane", cap_lane[16 + j], 0);
      end
      chk("layer_write_count", wcount, 20);

      // reset mid-neuron: outputs drop at once, nothing is written
      do_start();
      in_valid = 1'b1; in_data = 16'd7;
      @(posedge clk); #1;
      in_data = 16'd8;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_ch_idx", ch_idx, 0);
      chk("mid_rst_wr_en", wr_en, 0);
      chk("mid_rst_wr_data", wr_data, 0);
      chk("mid_rst_wr_addr", wr_addr, 0);
      chk("mid_rst_wr_lane", wr_lane, 0);
      chk("mid_rst_flags", {neuron_done, plane_done, layer_done}, 0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("post_rst_writes", wcount, 20);

      do_start();
      drive_neuron(5, 5, 5, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_data", cap_data[20], 15);
      chk("t5_addr", cap_addr[20], 0);
      chk("pending_writes", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
